inst_fetch_queue: RTL and testbench

Decoupling FIFO between the fetch stage and the decode stage. Buffers fetched instructions with their PC and branch-prediction data (`is_branch_taken`, `pht_index`) and presents the head entry to the decoder. Tracks delay-slot status across the handshake: the decoder's `is_next_delayslot` for the instruction being popped becomes `is_current_delayslot` for the next instruction presented. Sits directly upstream of the decoder and acts as the IF/ID mid-stage.

---
 rtl/inst_fetch_queue.sv | 127 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Fetch-to-decode decoupling queue carrying PC, instruction and branch-prediction data.
// Optional same-cycle bypass of an empty queue is enabled with `define FETCH_QUEUE_BYPASS_EN.
module inst_fetch_queue #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PTR_WIDTH = 3,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned INST_W    = 32,
    parameter int unsigned GHR_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 push_valid,
    output logic                 push_ready,
    input  logic [ADDR_W-1:0]    push_pc,
    input  logic [INST_W-1:0]    push_inst,
    input  logic                 push_branch_taken,
    input  logic [GHR_W-1:0]     push_pht_index,
    output logic                 pop_valid,
    input  logic                 pop_ready,
    output logic [ADDR_W-1:0]    pc_out,
    output logic [INST_W-1:0]    inst_out,
    output logic                 is_branch_taken_out,
    output logic [GHR_W-1:0]     pht_index_out,
    input  logic                 is_next_delayslot,
    output logic                 is_current_delayslot,
    output logic [PTR_WIDTH:0]   count
);

    localparam int unsigned CNT_W = PTR_WIDTH + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
        logic              taken;
        logic [GHR_W-1:0]  pht;
    } fq_entry_t;

    fq_entry_t            r_mem [DEPTH];
    logic [PTR_WIDTH-1:0] r_rp;
    logic [PTR_WIDTH-1:0] r_wp;
    logic [CNT_W-1:0]     r_count;
    logic                 r_ds;

    fq_entry_t w_push_entry;
    fq_entry_t w_head;
    logic      w_empty;
    logic      w_bypass;
    logic      w_bypass_take;
    logic      w_push_fire;
    logic      w_pop_fire;
    logic      w_push_wr;
    logic      w_pop_rd;

    assign w_push_entry = '{pc: push_pc, inst: push_inst, taken: push_branch_taken,
                            pht: push_pht_index};
    assign w_empty      = (r_count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue forwards the incoming entry straight to the head outputs.
    assign w_bypass = w_empty && push_valid && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign push_ready    = (r_count != FULL_CNT);
    assign pop_valid     = !w_empty || w_bypass;
    assign w_push_fire   = push_valid && push_ready;
    assign w_pop_fire    = pop_valid && pop_ready;
    assign w_bypass_take = w_bypass && pop_ready;

    // A bypassed entry consumed in the same cycle never touches storage or pointers.
    assign w_push_wr = w_push_fire && !w_bypass_take && !flush && !rst;
    assign w_pop_rd  = w_pop_fire && !w_bypass_take;

    // Head data: storage or bypass path, zeroed when nothing is presented.
    always_comb begin
        w_head               = w_bypass ? w_push_entry : r_mem[r_rp];
        pc_out               = '0;
        inst_out             = '0;
        is_branch_taken_out  = 1'b0;
        pht_index_out        = '0;
        if (pop_valid) begin
            pc_out              = w_head.pc;
            inst_out            = w_head.inst;
            is_branch_taken_out = w_head.taken;
            pht_index_out       = w_head.pht;
        end
    end

    assign is_current_delayslot = r_ds && pop_valid;
    assign count                = r_count;

    always_ff @(posedge clk) begin
        if (w_push_wr) begin
            r_mem[r_wp] <= w_push_entry;
        end
    end

    // Pointers, occupancy and delay-slot state.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rp    <= '0;
            r_wp    <= '0;
            r_count <= '0;
            r_ds    <= 1'b0;
        end else begin
            if (w_push_wr) begin
                r_wp <= r_wp + PTR_WIDTH'(1);
            end
            if (w_pop_rd) begin
                r_rp <= r_rp + PTR_WIDTH'(1);
            end
            case ({w_push_wr, w_pop_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // Delay-slot flag waits for whichever instruction pops next.
            if (w_pop_fire) begin
                r_ds <= is_next_delayslot;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised scoreboard bench for inst_fetch_queue with a queue-based reference model.
module tb_inst_fetch_queue;

    localparam int DEPTH = 8;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        bt;
        logic [7:0]  pht;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        push_valid = 1'b0;
    logic        push_ready;
    logic [31:0] push_pc = '0;
    logic [31:0] push_inst = '0;
    logic        push_branch_taken = 1'b0;
    logic [7:0]  push_pht_index = '0;
    logic        pop_valid;
    logic        pop_ready = 1'b0;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        is_branch_taken_out;
    logic [7:0]  pht_index_out;
    logic        is_next_delayslot = 1'b0;
    logic        is_current_delayslot;
    logic [3:0]  count;

    int   checks = 0;
    int   errors = 0;
    ent_t sb_q[$];
    int   m_count = 0;
    bit   m_ds = 1'b0;

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .DEPTH(8), .PTR_WIDTH(3), .ADDR_W(32), .INST_W(32), .GHR_W(8)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_pc(push_pc), .push_inst(push_inst),
        .push_branch_taken(push_branch_taken), .push_pht_index(push_pht_index),
        .pop_valid(pop_valid), .pop_ready(pop_ready),
        .pc_out(pc_out), .inst_out(inst_out),
        .is_branch_taken_out(is_branch_taken_out), .pht_index_out(pht_index_out),
        .is_next_delayslot(is_next_delayslot),
        .is_current_delayslot(is_current_delayslot),
        .count(count)
    );

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Monitor: every accepted head is compared with the oldest outstanding entry.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (pop_valid && pop_ready && !flush && !rst) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected at %0t: got pc 0x%0h expected no entry", $time, pc_out);
                end else begin
                    e = sb_q.pop_front();
                    if (pc_out != e.pc || inst_out != e.inst ||
                        is_branch_taken_out != e.bt || pht_index_out != e.pht) begin
                        errors++;
                        $display("FAIL pop_data at %0t: got pc=%h inst=%h bt=%b pht=%h expected pc=%h inst=%h bt=%b pht=%h",
                                 $time, pc_out, inst_out, is_branch_taken_out, pht_index_out,
                                 e.pc, e.inst, e.bt, e.pht);
                    end
                end
            end
        end
    end

    // One clock of stimulus, per-cycle status checks and reference-model update.
    task automatic cyc(input bit pv, input bit pr, input bit nds, input bit fl, input bit rs,
                       input logic [31:0] pc);
        bit   bp;
        bit   exp_pv;
        bit   acc;
        bit   pop;
        ent_t e;
        @(negedge clk);
        push_valid        = pv;
        push_pc           = pc;
        push_inst         = $urandom;
        push_branch_taken = 1'($urandom_range(1));
        push_pht_index    = 8'($urandom);
        pop_ready         = pr;
        is_next_delayslot = nds;
        flush             = fl;
        rst               = rs;
        bp     = BYPASS && (m_count == 0) && pv && !fl;
        exp_pv = (m_count != 0) || bp;
        acc    = pv && (m_count != DEPTH) && !fl && !rs;
        if (acc) begin
            e.pc = push_pc; e.inst = push_inst; e.bt = push_branch_taken; e.pht = push_pht_index;
            sb_q.push_back(e);
        end
        #1;
        chk("push_ready", 64'(push_ready), 64'(m_count != DEPTH));
        chk("pop_valid", 64'(pop_valid), 64'(exp_pv));
        chk("count", 64'(count), 64'(m_count));
        chk("cur_delayslot", 64'(is_current_delayslot), 64'(m_ds && exp_pv));
        if (!exp_pv) begin
            chk("idle_zero", {pc_out, inst_out}, 64'h0);
            chk("idle_zero_pred", 64'({is_branch_taken_out, pht_index_out}), 64'h0);
        end
        @(posedge clk);
        pop = exp_pv && pr;
        if (rs || fl) begin
            m_count = 0;
            m_ds    = 1'b0;
            sb_q.delete();
        end else begin
            m_count = m_count + int'(acc) - int'(pop);
            if (pop) m_ds = nds;
        end
    endtask

    initial begin
        bit pv, pr, fl, rs;
        int pr_pct;
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        // Three pushes held, then drained in order.
        cyc(1, 0, 0, 0, 0, 32'h100);
        cyc(1, 0, 0, 0, 0, 32'h104);
        cyc(1, 0, 0, 0, 0, 32'h108);
        cyc(0, 0, 0, 0, 0, 0);
        chk("head_pc_after_3", 64'(pc_out), 64'h100);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 0);
        // Fill, refused push with pop, then wrap-around traffic.
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, 0, 0, 32'h1000 + 32'(i * 4));
        cyc(1, 1, 0, 0, 0, 32'hBAD0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("count_after_full_pop", 64'(count), 64'd7);
        for (int i = 0; i < 16; i++) cyc(1, 1, 0, 0, 0, 32'h2000 + 32'(i * 4));
        for (int i = 0; i < DEPTH + 2; i++) cyc(0, 1, 0, 0, 0, 0);
        // Delay-slot flag survives an empty stretch.
        cyc(1, 0, 0, 0, 0, 32'h3000);
        cyc(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 32'h3004);
        cyc(1, 0, 0, 0, 0, 32'h3008);
        cyc(0, 0, 0, 0, 0, 0);
        chk("ds_after_gap", 64'(is_current_delayslot), 64'd1);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("ds_cleared", 64'(is_current_delayslot), 64'd0);
        cyc(0, 1, 0, 0, 0, 0);
        // Flush with 5 entries and ds set, colliding with push and pop.
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0, 32'h4000 + 32'(i * 4));
        cyc(0, 1, 1, 0, 0, 0);
        cyc(1, 1, 0, 1, 0, 32'hDEAD);
        cyc(0, 0, 0, 0, 0, 0);
        chk("flush_count", 64'(count), 64'd0);
        // Reset mid-traffic, then a fresh push becomes head.
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 32'h5000 + 32'(i * 4));
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 32'h200);
        cyc(0, 0, 0, 0, 0, 0);
        chk("head_after_rst", 64'(pc_out), 64'h200);
        cyc(0, 1, 0, 0, 0, 0);
        // Push onto an empty queue with the decoder ready.
        cyc(1, 1, 0, 0, 0, 32'h300);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        // Random traffic with phases biasing toward full and toward empty.
        for (int i = 0; i < 3000; i++) begin
            pr_pct = ((i / 300) % 2 == 0) ? 35 : 80;
            pv = ($urandom_range(99) < 70);
            pr = ($urandom_range(99) < pr_pct);
            fl = ($urandom_range(99) < 2);
            rs = ($urandom_range(199) < 1);
            if (rs) pv = 1'b0;
            cyc(pv, pr, 1'($urandom_range(1)), fl, rs, $urandom);
        end
        for (int i = 0; i < DEPTH + 2; i++) cyc(0, 1, 0, 0, 0, 0);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
